// File: rtl/alu_pkg.sv
// Shared definitions for the 8051-style ALU: op_code values, widths and the
// bundle of result fields carried from the combinational core to the register.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_NOP = 4'd0;
  localparam logic [OP_W-1:0] ALU_ADD = 4'd1;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd2;
  localparam logic [OP_W-1:0] ALU_MUL = 4'd3;
  localparam logic [OP_W-1:0] ALU_DIV = 4'd4;
  localparam logic [OP_W-1:0] ALU_DA  = 4'd5;
  localparam logic [OP_W-1:0] ALU_NOT = 4'd6;
  localparam logic [OP_W-1:0] ALU_AND = 4'd7;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd8;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd9;
  localparam logic [OP_W-1:0] ALU_RL  = 4'd10;
  localparam logic [OP_W-1:0] ALU_RLC = 4'd11;
  localparam logic [OP_W-1:0] ALU_RR  = 4'd12;
  localparam logic [OP_W-1:0] ALU_RRC = 4'd13;
  localparam logic [OP_W-1:0] ALU_INC = 4'd14;
  localparam logic [OP_W-1:0] ALU_XCH = 4'd15;

  typedef struct packed {
    logic [DATA_W-1:0] des1;
    logic [DATA_W-1:0] des2;
    logic [DATA_W-1:0] sub_result;
    logic              cy;
    logic              ac;
    logic              ov;
  } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: decodes op_code and produces the next value of
// every result field; the wrapper registers it.
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op_code,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] src3,
  input  logic              srcCy,
  input  logic              srcAc,
  input  logic              bit_in,
  output alu_res_t          o_res
);

  logic [DATA_W:0]     w_add;
  logic [DATA_W:0]     w_sub;
  logic [4:0]          w_add_nib;
  logic [4:0]          w_sub_nib;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_div_den;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W:0]     w_da1;
  logic [DATA_W:0]     w_da2;
  logic [2*DATA_W-1:0] w_inc;

  assign w_add     = {1'b0, src1} + {1'b0, src2} + {{DATA_W{1'b0}}, srcCy};
  assign w_sub     = {1'b0, src1} - {1'b0, src2} - {{DATA_W{1'b0}}, srcCy};
  assign w_add_nib = {1'b0, src1[3:0]} + {1'b0, src2[3:0]} + {4'd0, srcCy};
  assign w_sub_nib = {1'b0, src1[3:0]} - {1'b0, src2[3:0]} - {4'd0, srcCy};
  assign w_prod    = {{DATA_W{1'b0}}, src1} * {{DATA_W{1'b0}}, src2};

  // Divisor forced non-zero so the divider never sees x/0; the zero case is muxed out below.
  assign w_div_den = (src2 == '0) ? 8'd1 : src2;
  assign w_quot    = src1 / w_div_den;
  assign w_rem     = src1 % w_div_den;

  // Decimal adjust: the high-nibble step looks at the low-step result and its carry.
  assign w_da1 = ((src1[3:0] > 4'd9) || srcAc) ? ({1'b0, src1} + 9'h006) : {1'b0, src1};
  assign w_da2 = ((w_da1[7:4] > 4'd9) || srcCy || w_da1[8]) ?
                 ({1'b0, w_da1[7:0]} + 9'h060) : {1'b0, w_da1[7:0]};

  assign w_inc = {src3, src2} + 16'd1;

  always_comb begin
    o_res            = '0;
    o_res.des1       = src1;
    o_res.des2       = src2;
    o_res.sub_result = w_sub[DATA_W-1:0];
    o_res.cy         = srcCy;
    o_res.ac         = srcAc;
    o_res.ov         = 1'b0;
    unique case (op_code)
      ALU_NOP: ;
      ALU_ADD: begin
        o_res.des1 = w_add[DATA_W-1:0];
        o_res.cy   = w_add[DATA_W];
        o_res.ac   = w_add_nib[4];
        o_res.ov   = (src1[7] == src2[7]) && (w_add[7] != src1[7]);
      end
      ALU_SUB: begin
        o_res.des1 = w_sub[DATA_W-1:0];
        o_res.cy   = w_sub[DATA_W];
        o_res.ac   = w_sub_nib[4];
        o_res.ov   = (src1[7] != src2[7]) && (w_sub[7] != src1[7]);
      end
      ALU_MUL: begin
        o_res.des1 = w_prod[DATA_W-1:0];
        o_res.des2 = w_prod[2*DATA_W-1:DATA_W];
        o_res.cy   = 1'b0;
        o_res.ov   = |w_prod[2*DATA_W-1:DATA_W];
      end
      ALU_DIV: begin
        o_res.cy = 1'b0;
        if (src2 == '0) begin
          o_res.des1 = 8'hFF;
          o_res.des2 = 8'hFF;
          o_res.ov   = 1'b1;
        end else begin
          o_res.des1 = w_quot;
          o_res.des2 = w_rem;
        end
      end
      ALU_DA: begin
        o_res.des1 = w_da2[DATA_W-1:0];
        o_res.cy   = w_da1[8] | w_da2[8] | srcCy;
      end
      ALU_NOT: begin
        o_res.des1 = ~src1;
        o_res.cy   = ~srcCy;
      end
      ALU_AND: begin
        o_res.des1 = src1 & src2;
        o_res.cy   = srcCy & bit_in;
      end
      ALU_XOR: begin
        o_res.des1 = src1 ^ src2;
        o_res.cy   = srcCy ^ bit_in;
      end
      ALU_OR: begin
        o_res.des1 = src1 | src2;
        o_res.cy   = srcCy | bit_in;
      end
      ALU_RL:  o_res.des1 = {src1[6:0], src1[7]};
      ALU_RLC: begin
        o_res.des1 = {src1[6:0], srcCy};
        o_res.cy   = src1[7];
      end
      ALU_RR:  o_res.des1 = {src1[0], src1[7:1]};
      ALU_RRC: begin
        o_res.des1 = {srcCy, src1[7:1]};
        o_res.cy   = src1[0];
      end
      ALU_INC: begin
        o_res.des1 = w_inc[DATA_W-1:0];
        o_res.des2 = w_inc[2*DATA_W-1:DATA_W];
      end
      ALU_XCH: begin
        o_res.des1 = src2;
        o_res.des2 = src1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_modport.sv
// 8051-style ALU for the execute stage: combinational core followed by one
// output register, so every result appears one clock after its operands.
module alu_modport
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op_code,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] src3,
  input  logic              srcCy,
  input  logic              srcAc,
  input  logic              bit_in,
  output logic [DATA_W-1:0] des1,
  output logic [DATA_W-1:0] des2,
  output logic [DATA_W-1:0] des_acc,
  output logic [DATA_W-1:0] sub_result,
  output logic              desCy,
  output logic              desAc,
  output logic              desOv
);

  alu_res_t w_res_p0;
  alu_res_t r_res_p1;

  alu_core u_core (
    .op_code (op_code),
    .src1    (src1),
    .src2    (src2),
    .src3    (src3),
    .srcCy   (srcCy),
    .srcAc   (srcAc),
    .bit_in  (bit_in),
    .o_res   (w_res_p0)
  );

  // p0 -> p1: output register; reset clears results so nothing in flight survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_res_p1 <= '0;
    else     r_res_p1 <= w_res_p0;
  end

  assign des1       = r_res_p1.des1;
  assign des_acc    = r_res_p1.des1;
  assign des2       = r_res_p1.des2;
  assign sub_result = r_res_p1.sub_result;
  assign desCy      = r_res_p1.cy;
  assign desAc      = r_res_p1.ac;
  assign desOv      = r_res_p1.ov;

endmodule

// File: tb/tb_alu_modport.sv
// Directed bench for alu_modport: each task drives one scenario and checks the
// registered outputs against hand-computed values.
module tb_alu_modport;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] op_code;
  logic [7:0] src1, src2, src3;
  logic       srcCy, srcAc, bit_in;
  logic [7:0] des1, des2, des_acc, sub_result;
  logic       desCy, desAc, desOv;

  int errors = 0;
  int checks = 0;

  alu_modport dut (
    .clk        (clk),
    .rst        (rst),
    .op_code    (op_code),
    .src1       (src1),
    .src2       (src2),
    .src3       (src3),
    .srcCy      (srcCy),
    .srcAc      (srcAc),
    .bit_in     (bit_in),
    .des1       (des1),
    .des2       (des2),
    .des_acc    (des_acc),
    .sub_result (sub_result),
    .desCy      (desCy),
    .desAc      (desAc),
    .desOv      (desOv)
  );

  always #5 clk = ~clk;

  // Drive one op at the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic cy, input logic ac, input logic bi);
    @(negedge clk);
    op_code = op; src1 = a; src2 = b; src3 = c; srcCy = cy; srcAc = ac; bit_in = bi;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'd15, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    checks++;
    if ({des1, des2} !== 16'h3412) begin
      errors++; $display("FAIL reset_pre: got %h required %h", {des1, des2}, 16'h3412);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({des1, des2, des_acc, sub_result, desCy, desAc, desOv} !== 35'd0) begin
      errors++; $display("FAIL reset_async: got %h required 0", {des1, des2, des_acc, sub_result, desCy, desAc, desOv});
    end
    step();
    checks++;
    if ({des1, des2, des_acc, sub_result, desCy, desAc, desOv} !== 35'd0) begin
      errors++; $display("FAIL reset_hold: got %h required 0", {des1, des2, des_acc, sub_result, desCy, desAc, desOv});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({des1, des2, desCy, desAc} !== 18'd0) begin
      errors++; $display("FAIL reset_release: got %h required 0", {des1, des2, desCy, desAc});
    end
    step();
    checks++;
    if ({des1, des2, desCy, desAc, desOv} !== {8'h34, 8'h12, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_first_op: got %h required %h", {des1, des2, desCy, desAc, desOv}, {8'h34, 8'h12, 1'b1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_add();
    drive(4'd0, 8'h00, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, des2} !== 16'h0055) begin
      errors++; $display("FAIL nop: got %h required %h", {des1, des2}, 16'h0055);
    end
    drive(4'd1, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (des1 !== 8'h00) begin
      errors++; $display("FAIL add_latency: got %h required %h", des1, 8'h00);
    end
    step();
    checks++;
    if ({des1, des_acc, desCy, desAc, desOv, sub_result} !== {8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 8'h7E}) begin
      errors++; $display("FAIL add: got %h required %h", {des1, des_acc, desCy, desAc, desOv, sub_result}, {8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 8'h7E});
    end
  endtask

  task automatic test_sub();
    drive(4'd2, 8'h10, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy, desAc, desOv, sub_result} !== {8'hEF, 1'b1, 1'b1, 1'b0, 8'hEF}) begin
      errors++; $display("FAIL sub: got %h required %h", {des1, desCy, desAc, desOv, sub_result}, {8'hEF, 1'b1, 1'b1, 1'b0, 8'hEF});
    end
  endtask

  task automatic test_mul();
    drive(4'd3, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des2, des1, desCy, desOv} !== {8'hFE, 8'h01, 1'b0, 1'b1}) begin
      errors++; $display("FAIL mul: got %h required %h", {des2, des1, desCy, desOv}, {8'hFE, 8'h01, 1'b0, 1'b1});
    end
  endtask

  task automatic test_div();
    drive(4'd4, 8'h64, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, des2, desCy, desOv} !== {8'h0E, 8'h02, 1'b0, 1'b0}) begin
      errors++; $display("FAIL div: got %h required %h", {des1, des2, desCy, desOv}, {8'h0E, 8'h02, 1'b0, 1'b0});
    end
    drive(4'd4, 8'h42, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, des2, desCy, desOv} !== {8'hFF, 8'hFF, 1'b0, 1'b1}) begin
      errors++; $display("FAIL div_zero: got %h required %h", {des1, des2, desCy, desOv}, {8'hFF, 8'hFF, 1'b0, 1'b1});
    end
  endtask

  task automatic test_da();
    drive(4'd5, 8'h9A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL da: got %h required %h", {des1, desCy}, {8'h00, 1'b1});
    end
  endtask

  task automatic test_logic();
    drive(4'd7, 8'hF0, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy} !== {8'h30, 1'b0}) begin
      errors++; $display("FAIL and: got %h required %h", {des1, desCy}, {8'h30, 1'b0});
    end
    drive(4'd8, 8'hF0, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy} !== {8'hCC, 1'b1}) begin
      errors++; $display("FAIL xor: got %h required %h", {des1, desCy}, {8'hCC, 1'b1});
    end
    drive(4'd9, 8'hF0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if ({des1, desCy} !== {8'hFC, 1'b1}) begin
      errors++; $display("FAIL or: got %h required %h", {des1, desCy}, {8'hFC, 1'b1});
    end
    drive(4'd6, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy} !== {8'hA5, 1'b0}) begin
      errors++; $display("FAIL not: got %h required %h", {des1, desCy}, {8'hA5, 1'b0});
    end
  endtask

  task automatic test_rotate();
    drive(4'd11, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy} !== {8'h01, 1'b1}) begin
      errors++; $display("FAIL rlc: got %h required %h", {des1, desCy}, {8'h01, 1'b1});
    end
    drive(4'd10, 8'h81, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy} !== {8'h03, 1'b0}) begin
      errors++; $display("FAIL rl: got %h required %h", {des1, desCy}, {8'h03, 1'b0});
    end
    drive(4'd12, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy} !== {8'h80, 1'b0}) begin
      errors++; $display("FAIL rr: got %h required %h", {des1, desCy}, {8'h80, 1'b0});
    end
    drive(4'd13, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL rrc: got %h required %h", {des1, desCy}, {8'h00, 1'b1});
    end
  endtask

  task automatic test_inc_xch();
    drive(4'd14, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des2, des1, desCy, desAc, desOv} !== {8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL inc_wrap: got %h required %h", {des2, des1, desCy, desAc, desOv}, {8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    end
    drive(4'd14, 8'h00, 8'hFF, 8'h12, 1'b0, 1'b1, 1'b0);
    step();
    checks++;
    if ({des2, des1, desCy, desAc} !== {8'h13, 8'h00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL inc_carry: got %h required %h", {des2, des1, desCy, desAc}, {8'h13, 8'h00, 1'b0, 1'b1});
    end
    drive(4'd15, 8'hAB, 8'hCD, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, des2, des_acc} !== {8'hCD, 8'hAB, 8'hCD}) begin
      errors++; $display("FAIL xch: got %h required %h", {des1, des2, des_acc}, {8'hCD, 8'hAB, 8'hCD});
    end
  endtask

  task automatic test_back_to_back();
    drive(4'd1, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy, desAc, desOv} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_add: got %h required %h", {des1, desCy, desAc, desOv}, {8'h00, 1'b1, 1'b1, 1'b0});
    end
    drive(4'd2, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({des1, desCy, desAc, desOv, sub_result} !== {8'h7F, 1'b0, 1'b1, 1'b1, 8'h7F}) begin
      errors++; $display("FAIL b2b_sub: got %h required %h", {des1, desCy, desAc, desOv, sub_result}, {8'h7F, 1'b0, 1'b1, 1'b1, 8'h7F});
    end
    drive(4'd3, 8'h10, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({des2, des1, desCy, desOv, sub_result} !== {8'h00, 8'hF0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL b2b_mul: got %h required %h", {des2, des1, desCy, desOv, sub_result}, {8'h00, 8'hF0, 1'b0, 1'b0, 8'h00});
    end
  endtask

  initial begin
    rst = 1'b1;
    op_code = 4'd0; src1 = 8'h00; src2 = 8'h00; src3 = 8'h00;
    srcCy = 1'b0; srcAc = 1'b0; bit_in = 1'b0;
    #1;
    checks++;
    if ({des1, des2, des_acc, sub_result, desCy, desAc, desOv} !== 35'd0) begin
      errors++; $display("FAIL reset_initial: got %h required 0", {des1, des2, des_acc, sub_result, desCy, desAc, desOv});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_da();
    test_logic();
    test_rotate();
    test_inc_xch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
